// File: rtl/fb_fill_arbiter.sv
// Framebuffer write-port arbiter: a rectangle-free linear fill engine and
// the CPU share one registered word-write port, round-robin on contention.
//
// Ports:
//   ahb_clk, rst            sole clock, synchronous active-high reset
//   cpu_req/addr/wdata      CPU word write, held until cpu_gnt
//   cpu_gnt                 combinational accept of the CPU request
//   fill_start/base/len     one-cycle fill command, word base and count
//   fill_byte               gray value replicated into every byte
//   fill_wait_vblank, vblank  optionally defer the fill to blanking
//   fill_busy, fill_done    engine active / one-cycle completion pulse
//   fb_wen/waddr/wdata      registered framebuffer write port
module fb_fill_arbiter #(
  parameter int unsigned FB_AW      = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  ahb_clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [FB_AW-1:0]      cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  input  logic                  fill_start,
  input  logic [FB_AW-1:0]      fill_base,
  input  logic [FB_AW:0]        fill_len,
  input  logic [7:0]            fill_byte,
  input  logic                  fill_wait_vblank,
  input  logic                  vblank,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic                  fb_wen,
  output logic [FB_AW-1:0]      fb_waddr,
  output logic [DATA_WIDTH-1:0] fb_wdata
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VB,
    FILL,
    DONE
  } state_t;

  localparam logic [FB_AW-1:0] ADDR_ONE = 1;
  localparam logic [FB_AW:0]   REM_ONE  = 1;

  state_t state_q;
  state_t state_d;

  logic [FB_AW-1:0]      ptr_q;
  logic [FB_AW:0]        rem_q;
  logic [7:0]            byte_q;
  logic [DATA_WIDTH-1:0] fill_word;

  // Set when the CPU took the most recent grant; the other side wins
  // the next tie.
  logic last_cpu_q;

  logic fill_req;
  logic cpu_win;
  logic fill_win;

  assign fill_word = DATA_WIDTH'({4{byte_q}});

  // The FILL state lingers one cycle with rem_q==0 so fill_busy covers
  // the last write landing on the port; no request is made then.
  assign fill_req = (state_q == FILL) && (rem_q != '0);

  always_comb begin
    cpu_win  = 1'b0;
    fill_win = 1'b0;
    if (!rst) begin
      cpu_win  = cpu_req && (!fill_req || !last_cpu_q);
      fill_win = fill_req && !cpu_win;
    end
  end

  assign cpu_gnt = cpu_win;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          if (fill_len == '0) begin
            state_d = DONE;
          end else if (fill_wait_vblank) begin
            state_d = WAIT_VB;
          end else begin
            state_d = FILL;
          end
        end
      end
      WAIT_VB: begin
        if (vblank) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (rem_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fill_busy = (state_q == WAIT_VB) ||
                     (state_q == FILL);
  assign fill_done = (state_q == DONE);

  always_ff @(posedge ahb_clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Fill parameters are captured only in IDLE, so a mid-fill
  // fill_start cannot disturb them.
  always_ff @(posedge ahb_clk) begin
    if (rst) begin
      ptr_q  <= '0;
      rem_q  <= '0;
      byte_q <= '0;
    end else if (state_q == IDLE) begin
      if (fill_start) begin
        ptr_q  <= fill_base;
        rem_q  <= fill_len;
        byte_q <= fill_byte;
      end
    end else if (fill_win) begin
      ptr_q <= ptr_q + ADDR_ONE;
      rem_q <= rem_q - REM_ONE;
    end
  end

  always_ff @(posedge ahb_clk) begin
    if (rst) begin
      last_cpu_q <= 1'b0;
    end else if (cpu_win || fill_win) begin
      last_cpu_q <= cpu_win;
    end
  end

  always_ff @(posedge ahb_clk) begin
    if (rst) begin
      fb_wen   <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= '0;
    end else begin
      fb_wen <= cpu_win || fill_win;
      unique case (1'b1)
        cpu_win: begin
          fb_waddr <= cpu_addr;
          fb_wdata <= cpu_wdata;
        end
        fill_win: begin
          fb_waddr <= ptr_q;
          fb_wdata <= fill_word;
        end
        default: begin
          fb_waddr <= fb_waddr;
          fb_wdata <= fb_wdata;
        end
      endcase
    end
  end

endmodule
